// File: rtl/ff_share_arb.sv
// ff_share_arb: arbiter sharing one W-bit register among NREQ writers via a grant stage and a commit stage.
// Build option: define FF_ARB_FIXED_PRIO_EN for lowest-index-first arbitration instead of round-robin.
module ff_share_arb #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*W-1:0]       wdata,
    input  logic                    clr,
    output logic [NREQ-1:0]         gnt,
    output logic [W-1:0]            q,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    wr_done,
    output logic                    busy
);
    localparam int unsigned IW = $clog2(NREQ);

    logic [NREQ-1:0] eligible_c;
    logic            win_vld_c;
    logic [IW-1:0]   win_idx_c;
    logic [NREQ-1:0] win_oh_c;
    logic [W-1:0]    win_data_c;

    logic            sv;
    logic [W-1:0]    sd;
    logic [IW-1:0]   sid;

    logic            en_c;
    logic [W-1:0]    d_c;
    logic [W-1:0]    r_next_c;
    logic [W-1:0]    r;

    // The current grantee sits out one cycle so a held request cannot monopolise the register.
    assign eligible_c = req & ~gnt;

`ifdef FF_ARB_FIXED_PRIO_EN
    always_comb begin
        win_vld_c = 1'b0;
        win_idx_c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!win_vld_c && eligible_c[IW'(i)]) begin
                win_vld_c = 1'b1;
                win_idx_c = IW'(i);
            end
        end
    end
`else
    logic [IW-1:0] ptr;
    logic [IW-1:0] ptr_next_c;

    // Search starts at ptr and wraps, so the first eligible index at or after ptr wins.
    always_comb begin
        int unsigned idx;
        win_vld_c = 1'b0;
        win_idx_c = '0;
        idx       = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!win_vld_c && eligible_c[IW'(idx)]) begin
                win_vld_c = 1'b1;
                win_idx_c = IW'(idx);
            end
        end
    end

    always_comb begin
        ptr_next_c = ptr;
        if (win_vld_c) begin
            ptr_next_c = (win_idx_c == IW'(NREQ - 1)) ? '0 : win_idx_c + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_next_c;
        end
    end
`endif

    assign win_oh_c   = win_vld_c ? (NREQ'(1) << win_idx_c) : '0;
    assign win_data_c = wdata[32'(win_idx_c) * W +: W];

    // Grant stage: one-hot pulse plus the winner's data and index held for commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt <= '0;
            sv  <= 1'b0;
            sd  <= '0;
            sid <= '0;
        end else begin
            gnt <= win_oh_c;
            sv  <= win_vld_c;
            if (win_vld_c) begin
                sd  <= win_data_c;
                sid <= win_idx_c;
            end
        end
    end

    assign en_c = sv;
    assign d_c  = sd;

    // Storage next-state; clear overrides a pending commit.
    always_comb begin
        r_next_c = r;
        if (clr) begin
            r_next_c = '0;
        end else if (en_c) begin
            r_next_c = d_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r       <= '0;
            owner   <= '0;
            wr_done <= 1'b0;
        end else begin
            r       <= r_next_c;
            wr_done <= en_c & ~clr;
            if (clr) begin
                owner <= '0;
            end else if (en_c) begin
                owner <= sid;
            end
        end
    end

    assign q    = r;
    assign busy = sv;

endmodule

// File: tb/tb_ff_share_arb.sv
// Scoreboard bench for ff_share_arb: a transaction model predicts grants and commits, a monitor checks them.
// Honours FF_ARB_FIXED_PRIO_EN in the reference model and the fairness expectations.
module tb_ff_share_arb;
    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 8;
    localparam int unsigned IW   = $clog2(NREQ);

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req   = '0;
    logic [NREQ*W-1:0] wdata = '0;
    logic              clr   = 1'b0;
    logic [NREQ-1:0]   gnt;
    logic [W-1:0]      q;
    logic [IW-1:0]     owner;
    logic              wr_done;
    logic              busy;

    typedef struct {
        logic [W-1:0] data;
        int           id;
        int           edge_n;
    } commit_t;

    commit_t         exp_q[$];
    int              cyc         = 0;
    logic [NREQ-1:0] m_gnt       = '0;
    int              m_ptr       = 0;
    logic [W-1:0]    m_q         = '0;
    int              m_owner     = 0;
    int              vectors     = 0;
    int              miscompares = 0;

    ff_share_arb #(.NREQ(NREQ), .W(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .wdata   (wdata),
        .clr     (clr),
        .gnt     (gnt),
        .q       (q),
        .owner   (owner),
        .wr_done (wr_done),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: pick a winner from the rules, queue its commit for the following edge.
    always @(posedge clk or negedge rst_n) begin
        int              win;
        int              cand;
        logic [NREQ-1:0] elig;
        commit_t         c;
        if (!rst_n) begin
            m_gnt   = '0;
            m_ptr   = 0;
            m_q     = '0;
            m_owner = 0;
            exp_q.delete();
        end else begin
            cyc++;
            if (exp_q.size() > 0 && exp_q[0].edge_n == cyc) begin
                if (clr) begin
                    void'(exp_q.pop_front());
                end else begin
                    m_q     = exp_q[0].data;
                    m_owner = exp_q[0].id;
                end
            end
            if (clr) begin
                m_q     = '0;
                m_owner = 0;
            end
            elig = req & ~m_gnt;
            win  = -1;
            for (int k = 0; k < int'(NREQ); k++) begin
`ifdef FF_ARB_FIXED_PRIO_EN
                cand = k;
`else
                cand = (m_ptr + k) % int'(NREQ);
`endif
                if (win < 0 && elig[cand]) win = cand;
            end
            m_gnt = '0;
            if (win >= 0) begin
                m_gnt[win] = 1'b1;
                c.data     = wdata[win*W +: W];
                c.id       = win;
                c.edge_n   = cyc + 1;
                exp_q.push_back(c);
                m_ptr = (win + 1) % int'(NREQ);
            end
        end
    end

    // Monitor: compare outputs every cycle and retire queued commits on wr_done.
    always @(negedge clk) begin
        commit_t c;
        if (rst_n) begin
            chk("gnt", int'(gnt), int'(m_gnt));
            chk("q", int'(q), int'(m_q));
            chk("owner", int'(owner), m_owner);
            chk("busy", int'(busy),
                int'(exp_q.size() > 0 && exp_q[exp_q.size()-1].edge_n == cyc + 1));
            if (wr_done) begin
                if (exp_q.size() == 0) begin
                    chk("wr_done_spurious", int'(wr_done), 0);
                end else begin
                    c = exp_q.pop_front();
                    chk("commit_edge", cyc, c.edge_n);
                    chk("commit_q", int'(q), int'(c.data));
                    chk("commit_owner", int'(owner), c.id);
                end
            end else if (exp_q.size() > 0 && exp_q[0].edge_n <= cyc) begin
                chk("wr_done_missing", int'(wr_done), 1);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic step(input logic [NREQ-1:0] r, input logic c);
        @(negedge clk);
        req = r;
        clr = c;
    endtask

    task automatic set_data(input int i, input logic [W-1:0] v);
        wdata[i*W +: W] = v;
    endtask

    int fair_idx[5];

    initial begin
`ifdef FF_ARB_FIXED_PRIO_EN
        fair_idx = '{0, 1, 0, 1, 0};
`else
        fair_idx = '{0, 1, 2, 3, 0};
`endif
        repeat (2) @(negedge clk);
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_q", int'(q), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_wr_done", int'(wr_done), 0);
        rst_n = 1'b1;

        // single write from requester 2
        set_data(2, 8'hA5);
        step(4'b0100, 1'b0);
        step(4'b0000, 1'b0);
        chk("single_gnt", int'(gnt), 4'b0100);
        step(4'b0000, 1'b0);
        chk("single_q", int'(q), 8'hA5);
        chk("single_owner", int'(owner), 2);
        chk("single_wr_done", int'(wr_done), 1);

        // reset dropped while a write is pending
        set_data(1, 8'h77);
        step(4'b0010, 1'b0);
        step(4'b0000, 1'b0);
        chk("prerst_busy", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_q", int'(q), 0);
        chk("midrst_gnt", int'(gnt), 0);
        chk("midrst_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        step(4'b0000, 1'b0);
        chk("postrst_wr_done", int'(wr_done), 0);
        step(4'b0000, 1'b0);
        chk("postrst_wr_done2", int'(wr_done), 0);

        // fairness with all requesters held
        for (int i = 0; i < int'(NREQ); i++) set_data(i, W'(8'h10 * (i + 1)));
        step(4'b1111, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(4'b1111, 1'b0);
            chk("fair_gnt", int'(gnt), 1 << fair_idx[k]);
            if (k > 0) chk("fair_q", int'(q), 8'h10 * (fair_idx[k-1] + 1));
        end
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);
        chk("idle_gnt", int'(gnt), 0);
        chk("idle_busy", int'(busy), 0);

        // single persistent requester alternates
        step(4'b0001, 1'b0);
        for (int k = 0; k < 6; k++) begin
            step(4'b0001, 1'b0);
            chk("persist_gnt", int'(gnt[0]), int'(k % 2 == 0));
            chk("persist_wr_done", int'(wr_done), int'(k % 2 == 1));
        end
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);

        // clear collides with a stage-2 commit while a new grant is issued
        set_data(2, 8'h3C);
        step(4'b0100, 1'b0);
        set_data(3, 8'h5A);
        step(4'b1000, 1'b1);
        chk("clr_pre_busy", int'(busy), 1);
        step(4'b0000, 1'b0);
        chk("clr_q", int'(q), 0);
        chk("clr_wr_done", int'(wr_done), 0);
        chk("clr_gnt", int'(gnt), 4'b1000);
        step(4'b0000, 1'b0);
        chk("clr_next_q", int'(q), 8'h5A);
        chk("clr_next_wr_done", int'(wr_done), 1);
        chk("clr_next_owner", int'(owner), 3);

        // data changed in the grant cycle must not leak into q
        set_data(1, 8'h11);
        step(4'b0010, 1'b0);
        step(4'b0000, 1'b0);
        set_data(1, 8'h22);
        chk("samp_gnt", int'(gnt), 4'b0010);
        step(4'b0000, 1'b0);
        chk("samp_q", int'(q), 8'h11);

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            step(NREQ'($urandom), 1'($urandom_range(7) == 0));
            wdata = (NREQ*W)'($urandom);
        end
        repeat (3) step(4'b0000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
